// File: rtl/sccb_pkg.sv
// Shared definitions for the SCCB request arbiter and the SCCB transaction engine.
// Optional feature macro used by the arbiter: SCCB_RETRY_EN (NACK retry).
package sccb_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    // OV7670 device address bytes as they appear on the SCCB bus.
    localparam logic [7:0] OV7670_WR_ADDR = 8'h42;
    localparam logic [7:0] OV7670_RD_ADDR = 8'h43;

    // Roughly 20 ms at 100 MHz, generous for a single slow SCCB transfer.
    localparam int DEFAULT_TIMEOUT_CYC = 2_000_000;
    localparam int DEFAULT_RETRY_MAX   = 3;

    // Width needed to hold values 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first active request
// at or after the pointer, wrapping around.
module rr_arbiter
    import sccb_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]              req,
    input  logic [cnt_width(N)-1:0]   ptr,
    output logic [N-1:0]              grant,
    output logic [cnt_width(N)-1:0]   idx
);

    localparam int IW = cnt_width(N);

    logic found;
    int   pos;

    // Scan from the pointer upward, taking the first requester that is valid.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int k = 0; k < N; k++) begin
            pos = (int'(ptr) + k) % N;
            if (!found && req[pos]) begin
                found      = 1'b1;
                grant[pos] = 1'b1;
                idx        = IW'(pos);
            end
        end
    end

endmodule

// File: rtl/sccb_req_arbiter.sv
// Shares one SCCB transaction engine between NUM_REQ requesters.
// Round-robin grants, start/done handshake with a timeout guard, and a
// one-cycle response pulse back to the granted requester.
// Define SCCB_RETRY_EN to retry NACKed transactions up to RETRY_MAX times.
module sccb_req_arbiter
    import sccb_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
`ifdef SCCB_RETRY_EN
    ,
    parameter int RETRY_MAX   = DEFAULT_RETRY_MAX
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ-1:0]    req_rd,
    input  logic [8*NUM_REQ-1:0]  req_addr,
    input  logic [8*NUM_REQ-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [7:0]            rsp_rdata,
    output logic                  rsp_err,
    output logic                  eng_start,
    output logic                  eng_rd,
    output logic [7:0]            eng_addr,
    output logic [7:0]            eng_wdata,
    output logic                  eng_abort,
    input  logic                  eng_done,
    input  logic                  eng_nack,
    input  logic [7:0]            eng_rdata,
    output logic                  busy,
    output logic [7:0]            err_count
);

    localparam int IW = cnt_width(NUM_REQ);
    localparam int CW = cnt_width(TIMEOUT_CYC);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_REQ - 1);

    state_t          state;
    state_t          state_next;
    logic [IW-1:0]   ptr;
    logic [NUM_REQ-1:0] grant;
    logic [IW-1:0]   grant_idx;
    logic            accept;

    logic [IW-1:0]   idx_q;
    logic            rd_q;
    logic [7:0]      addr_q;
    logic [7:0]      wdata_q;
    logic [7:0]      rdata_q;
    logic            err_q;
    logic [CW-1:0]   cnt;
    logic [7:0]      err_count_q;

`ifdef SCCB_RETRY_EN
    localparam logic [7:0] RETRY_LIMIT = 8'(RETRY_MAX);
    logic [7:0]      retry_cnt;
    logic            retry;
`endif

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr_arbiter (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (grant_idx)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and handshake outputs; everything is held low while reset is asserted.
    always_comb begin
        state_next = state;
        req_ready  = '0;
        rsp_valid  = '0;
        rsp_rdata  = 8'h00;
        rsp_err    = 1'b0;
        eng_start  = 1'b0;
        eng_abort  = 1'b0;
        accept     = 1'b0;
`ifdef SCCB_RETRY_EN
        retry      = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (|req_valid) begin
                    req_ready  = grant;
                    accept     = 1'b1;
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                eng_start  = 1'b1;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (eng_done) begin
`ifdef SCCB_RETRY_EN
                    if (eng_nack && (retry_cnt < RETRY_LIMIT)) begin
                        retry      = 1'b1;
                        state_next = S_ISSUE;
                    end else begin
                        state_next = S_RESP;
                    end
`else
                    state_next = S_RESP;
`endif
                end else if (cnt == CNT_LAST) begin
                    eng_abort  = 1'b1;
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid  = NUM_REQ'(1) << idx_q;
                rsp_rdata  = rdata_q;
                rsp_err    = err_q;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
        if (reset) begin
            req_ready = '0;
            rsp_valid = '0;
            rsp_rdata = 8'h00;
            rsp_err   = 1'b0;
            eng_start = 1'b0;
            eng_abort = 1'b0;
        end
    end

    // Request capture, timeout counter, result latch, pointer and error counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr         <= '0;
            idx_q       <= '0;
            rd_q        <= 1'b0;
            addr_q      <= 8'h00;
            wdata_q     <= 8'h00;
            rdata_q     <= 8'h00;
            err_q       <= 1'b0;
            cnt         <= '0;
            err_count_q <= 8'h00;
`ifdef SCCB_RETRY_EN
            retry_cnt   <= 8'h00;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        idx_q     <= grant_idx;
                        rd_q      <= req_rd[grant_idx];
                        addr_q    <= req_addr[int'(grant_idx)*8 +: 8];
                        wdata_q   <= req_wdata[int'(grant_idx)*8 +: 8];
`ifdef SCCB_RETRY_EN
                        retry_cnt <= 8'h00;
`endif
                    end
                end
                S_ISSUE: begin
                    cnt <= '0;
                end
                S_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (eng_done) begin
                        rdata_q <= rd_q ? eng_rdata : 8'h00;
                        err_q   <= eng_nack;
`ifdef SCCB_RETRY_EN
                        if (retry) begin
                            retry_cnt <= retry_cnt + 1'b1;
                        end
`endif
                    end else if (cnt == CNT_LAST) begin
                        rdata_q <= 8'h00;
                        err_q   <= 1'b1;
                    end
                end
                S_RESP: begin
                    ptr <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                    if (err_q && (err_count_q != 8'hFF)) begin
                        err_count_q <= err_count_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign eng_rd    = rd_q;
    assign eng_addr  = addr_q;
    assign eng_wdata = wdata_q;
    assign busy      = (state != S_IDLE);
    assign err_count = err_count_q;

endmodule

// File: tb/tb_sccb_req_arbiter.sv
// Testbench for sccb_req_arbiter: a cycle table for the basic handshakes,
// directed multi-cycle sequences and randomized transactions checked against
// a transaction-level model. Honors SCCB_RETRY_EN if defined.
module tb_sccb_req_arbiter;

    localparam int N  = 3;
    localparam int TO = 16;
    localparam int RETRY_MAX_TB = 3;
`ifdef SCCB_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   req_rd;
    logic [8*N-1:0] req_addr;
    logic [8*N-1:0] req_wdata;
    logic [N-1:0]   rsp_valid;
    logic [7:0]     rsp_rdata;
    logic           rsp_err;
    logic           eng_start;
    logic           eng_rd;
    logic [7:0]     eng_addr;
    logic [7:0]     eng_wdata;
    logic           eng_abort;
    logic           eng_done;
    logic           eng_nack;
    logic [7:0]     eng_rdata;
    logic           busy;
    logic [7:0]     err_count;

    int checks = 0;
    int errors = 0;
    int model_ptr = 0;
    int model_errs = 0;

    sccb_req_arbiter #(
        .NUM_REQ     (N),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rd    (req_rd),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .eng_start (eng_start),
        .eng_rd    (eng_rd),
        .eng_addr  (eng_addr),
        .eng_wdata (eng_wdata),
        .eng_abort (eng_abort),
        .eng_done  (eng_done),
        .eng_nack  (eng_nack),
        .eng_rdata (eng_rdata),
        .busy      (busy),
        .err_count (err_count)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] valid;
        logic [2:0] rd;
        logic       done;
        logic       nack;
        logic [7:0] rdata;
        logic [2:0] e_ready;
        logic       e_start;
        logic       e_chk;
        logic [7:0] e_addr;
        logic [7:0] e_wdata;
        logic       e_rd;
        logic [2:0] e_rsp;
        logic [7:0] e_rdata;
        logic       e_err;
        logic       e_busy;
    } vec_t;

    vec_t vecs[13];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        req_valid = v.valid;
        req_rd    = v.rd;
        req_addr  = 24'h99_0A_12;
        req_wdata = 24'h00_5A_80;
        eng_done  = v.done;
        eng_nack  = v.nack;
        eng_rdata = v.rdata;
    endtask

    task automatic noise();
        req_valid = N'($urandom);
        req_rd    = N'($urandom);
        req_addr  = (8*N)'($urandom);
        req_wdata = (8*N)'($urandom);
    endtask

    // One complete request as seen from the requester and the engine side.
    // Called right after a rising edge with the DUT idle; returns the same way.
    task automatic runTxn(input logic [N-1:0] valid, input logic [N-1:0] rd,
                          input logic [8*N-1:0] addr, input logic [8*N-1:0] wdata,
                          input int n_nack, input bit to_mode, input int delay,
                          input logic [7:0] rdata, output int granted, output int starts);
        int  g;
        int  j;
        int  d;
        bit  this_nack;
        bit  done_now;
        bit  finished;
        bit  err_exp;
        logic [7:0] rdata_exp;
        g = -1;
        for (int k = 0; k < N; k++) begin
            if (g < 0 && valid[(model_ptr + k) % N]) g = (model_ptr + k) % N;
        end
        req_valid = valid;
        req_rd    = rd;
        req_addr  = addr;
        req_wdata = wdata;
        eng_done  = 1'b0;
        eng_nack  = 1'b0;
        @(negedge clk);
        checkOutput("idle_busy", 32'(busy), 0);
        checkOutput("err_count", 32'(err_count), 32'(model_errs));
        checkOutput("req_ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 0);
        granted = g;
        starts  = 0;
        if (g < 0) begin
            tick();
            return;
        end
        j = 0;
        finished = 1'b0;
        done_now = 1'b0;
        this_nack = 1'b0;
        while (!finished) begin
            tick();
            noise();
            eng_done = 1'($urandom);
            eng_nack = 1'b1;
            @(negedge clk);
            checkOutput("eng_start", 32'(eng_start), 1);
            checkOutput("eng_addr", 32'(eng_addr), 32'(addr[8*g +: 8]));
            checkOutput("eng_wdata", 32'(eng_wdata), 32'(wdata[8*g +: 8]));
            checkOutput("eng_rd", 32'(eng_rd), 32'(rd[g]));
            checkOutput("busy_ready", 32'(req_ready), 0);
            starts++;
            d = (delay < 0) ? int'($urandom_range(0, TO - 1)) : delay;
            this_nack = (j < n_nack);
            done_now = 1'b0;
            for (int k = 0; k < TO; k++) begin
                tick();
                noise();
                eng_done  = 1'b0;
                eng_nack  = 1'($urandom);
                eng_rdata = 8'($urandom);
                done_now  = (k == d) && (this_nack || !to_mode);
                if (done_now) begin
                    eng_done  = 1'b1;
                    eng_nack  = this_nack;
                    eng_rdata = rdata;
                end
                @(negedge clk);
                checkOutput("wait_start", 32'(eng_start), 0);
                checkOutput("wait_rsp", 32'(rsp_valid), 0);
                checkOutput("wait_ready", 32'(req_ready), 0);
                checkOutput("wait_addr", 32'(eng_addr), 32'(addr[8*g +: 8]));
                checkOutput("eng_abort", 32'(eng_abort), ((k == TO - 1) && !done_now) ? 1 : 0);
                if (done_now || k == TO - 1) break;
            end
            if (done_now && this_nack && RETRY_EN && j < RETRY_MAX_TB) begin
                j++;
                continue;
            end
            err_exp   = done_now ? this_nack : 1'b1;
            rdata_exp = (done_now && rd[g]) ? rdata : 8'h00;
            tick();
            noise();
            eng_done = 1'b1;
            eng_nack = 1'b1;
            @(negedge clk);
            checkOutput("rsp_valid", 32'(rsp_valid), 32'd1 << g);
            checkOutput("rsp_rdata", 32'(rsp_rdata), 32'(rdata_exp));
            checkOutput("rsp_err", 32'(rsp_err), 32'(err_exp));
            checkOutput("rsp_abort", 32'(eng_abort), 0);
            checkOutput("rsp_start", 32'(eng_start), 0);
            model_ptr = (g + 1) % N;
            if (err_exp && model_errs < 255) model_errs++;
            tick();
            req_valid = '0;
            eng_done  = 1'b0;
            eng_nack  = 1'b0;
            finished  = 1'b1;
        end
    endtask

    initial begin
        int g;
        int s;
        int nn;
        vecs[0]  = '{3'b000, 3'b000, 1'b0, 1'b0, 8'h00, 3'b000, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0};
        vecs[1]  = '{3'b001, 3'b000, 1'b0, 1'b0, 8'h00, 3'b001, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0};
        vecs[2]  = '{3'b000, 3'b000, 1'b0, 1'b0, 8'h00, 3'b000, 1'b1, 1'b1, 8'h12, 8'h80, 1'b0, 3'b000, 8'h00, 1'b0, 1'b1};
        vecs[3]  = '{3'b000, 3'b000, 1'b1, 1'b0, 8'h55, 3'b000, 1'b0, 1'b1, 8'h12, 8'h80, 1'b0, 3'b000, 8'h00, 1'b0, 1'b1};
        vecs[4]  = '{3'b000, 3'b000, 1'b0, 1'b0, 8'h00, 3'b000, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 3'b001, 8'h00, 1'b0, 1'b1};
        vecs[5]  = '{3'b010, 3'b010, 1'b0, 1'b0, 8'h00, 3'b010, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0};
        vecs[6]  = '{3'b000, 3'b000, 1'b0, 1'b0, 8'h00, 3'b000, 1'b1, 1'b1, 8'h0A, 8'h5A, 1'b1, 3'b000, 8'h00, 1'b0, 1'b1};
        vecs[7]  = '{3'b000, 3'b000, 1'b0, 1'b0, 8'h00, 3'b000, 1'b0, 1'b1, 8'h0A, 8'h5A, 1'b1, 3'b000, 8'h00, 1'b0, 1'b1};
        vecs[8]  = '{3'b000, 3'b000, 1'b1, 1'b0, 8'h76, 3'b000, 1'b0, 1'b1, 8'h0A, 8'h5A, 1'b1, 3'b000, 8'h00, 1'b0, 1'b1};
        vecs[9]  = '{3'b000, 3'b000, 1'b0, 1'b0, 8'h00, 3'b000, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 3'b010, 8'h76, 1'b0, 1'b1};
        vecs[10] = '{3'b011, 3'b010, 1'b1, 1'b1, 8'hAA, 3'b001, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0};
        vecs[11] = '{3'b000, 3'b000, 1'b1, 1'b1, 8'hAA, 3'b000, 1'b1, 1'b1, 8'h12, 8'h80, 1'b0, 3'b000, 8'h00, 1'b0, 1'b1};
        vecs[12] = '{3'b000, 3'b000, 1'b0, 1'b0, 8'h00, 3'b000, 1'b0, 1'b1, 8'h12, 8'h80, 1'b0, 3'b000, 8'h00, 1'b0, 1'b1};

        reset     = 1'b1;
        req_valid = '0;
        req_rd    = '0;
        req_addr  = '0;
        req_wdata = '0;
        eng_done  = 1'b0;
        eng_nack  = 1'b0;
        eng_rdata = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        $display("[TB] cycle table");
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput($sformatf("v%0d_ready", i), 32'(req_ready), 32'(vecs[i].e_ready));
            checkOutput($sformatf("v%0d_start", i), 32'(eng_start), 32'(vecs[i].e_start));
            checkOutput($sformatf("v%0d_rsp", i), 32'(rsp_valid), 32'(vecs[i].e_rsp));
            checkOutput($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
            checkOutput($sformatf("v%0d_abort", i), 32'(eng_abort), 0);
            if (i == 0) checkOutput("reset_err_count", 32'(err_count), 0);
            if (vecs[i].e_chk) begin
                checkOutput($sformatf("v%0d_addr", i), 32'(eng_addr), 32'(vecs[i].e_addr));
                checkOutput($sformatf("v%0d_wdata", i), 32'(eng_wdata), 32'(vecs[i].e_wdata));
                checkOutput($sformatf("v%0d_rd", i), 32'(eng_rd), 32'(vecs[i].e_rd));
            end
            if (vecs[i].e_rsp != 3'b000) begin
                checkOutput($sformatf("v%0d_rdata", i), 32'(rsp_rdata), 32'(vecs[i].e_rdata));
                checkOutput($sformatf("v%0d_err", i), 32'(rsp_err), 32'(vecs[i].e_err));
            end
            tick();
        end

        $display("[TB] reset while waiting on the engine");
        reset    = 1'b1;
        eng_done = 1'b1;
        eng_nack = 1'b1;
        @(negedge clk);
        checkOutput("rst_rsp_during", 32'(rsp_valid), 0);
        checkOutput("rst_abort_during", 32'(eng_abort), 0);
        tick();
        reset    = 1'b0;
        eng_done = 1'b0;
        eng_nack = 1'b0;
        @(negedge clk);
        checkOutput("rst_ready", 32'(req_ready), 0);
        checkOutput("rst_start", 32'(eng_start), 0);
        checkOutput("rst_abort", 32'(eng_abort), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_err_count", 32'(err_count), 0);
        checkOutput("rst_addr", 32'(eng_addr), 0);
        checkOutput("rst_wdata", 32'(eng_wdata), 0);
        checkOutput("rst_eng_rd", 32'(eng_rd), 0);
        checkOutput("rst_rdata", 32'(rsp_rdata), 0);
        checkOutput("rst_err", 32'(rsp_err), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            checkOutput("rst_no_rsp", 32'(rsp_valid), 0);
            checkOutput("rst_idle", 32'(busy), 0);
        end
        tick();
        model_ptr  = 0;
        model_errs = 0;
        runTxn(3'b110, 3'b000, 24'h33_22_11, 24'h66_55_44, 0, 1'b0, 3, 8'h00, g, s);
        checkOutput("rst_ptr_grant", 32'(g), 1);

        $display("[TB] fairness");
        for (int i = 0; i < 4; i++) begin
            runTxn(3'b011, 3'b000, 24'h00_B1_A0 + 24'(i), 24'h00_11_22, 0, 1'b0, 1, 8'h00, g, s);
            checkOutput("fair_order", 32'(g), (i % 2 == 0) ? 0 : 1);
        end

        $display("[TB] nack, timeout and same-cycle done");
        runTxn(3'b100, 3'b000, 24'h3A_00_00, 24'hC3_00_00, 3, 1'b0, 2, 8'h00, g, s);
        checkOutput("nack_starts", 32'(s), RETRY_EN ? 4 : 1);
        runTxn(3'b001, 3'b000, 24'h00_00_10, 24'h00_00_20, 0, 1'b1, 0, 8'h00, g, s);
        checkOutput("timeout_starts", 32'(s), 1);
        runTxn(3'b010, 3'b010, 24'h00_0B_00, 24'h00_00_00, 0, 1'b0, TO - 1, 8'h3C, g, s);

        $display("[TB] randomized transactions");
        for (int i = 0; i < 80; i++) begin
            nn = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            runTxn(3'($urandom_range(1, 7)), 3'($urandom), 24'($urandom), 24'($urandom),
                   nn, ($urandom_range(0, 4) == 0), -1, 8'($urandom), g, s);
        end

        $display("[TB] error counter saturation");
        for (int i = 0; i < 260; i++) begin
            runTxn(3'($urandom_range(1, 7)), 3'($urandom), 24'($urandom), 24'($urandom),
                   RETRY_MAX_TB + 1, 1'b0, 0, 8'($urandom), g, s);
        end
        @(negedge clk);
        checkOutput("err_sat", 32'(err_count), 32'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
